result_display: RTL and testbench

RESULT_DISPLAY -- requirements
Module: result_display

---
 rtl/result_display_pkg.sv | 20 ++
 rtl/result_display_seg_decode.sv | 12 +
 rtl/result_display.sv | 162 ++++++++++++++++
 tb/tb_result_display.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_pkg.sv
// Shared types and constants for result_display: FSM states and the active-low
// seven-segment glyph table ({g,f,e,d,c,b,a}).
package result_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/result_display_seg_decode.sv
// Hex digit to active-low segment pattern, with a blank override.
module seg_decode
    import result_display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? BLANK_SEG : HEX_SEG[value];

endmodule

// File: rtl/result_display.sv
// Captures an ALU result and opcode and scans them onto a 4-digit multiplexed display.
// RESULT_DISPLAY_DECIMAL_EN selects unsigned decimal digits (double-dabble); default is hex.
module result_display
    import result_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic [3:0] sel,
    input  logic       enable,
    input  logic       load,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    state_t      state, next_state;
    logic        accept;
    logic [7:0]  sh_data;
    logic [3:0]  sh_sel;
    logic [3:0]  disp_op, disp_mid, disp_lo;
    logic [CW-1:0] refresh;
    logic [1:0]  digit;
    logic [3:0]  cur_val;
    logic        cur_blank;
    logic [6:0]  cur_seg;

    assign accept = (state == IDLE) && load && enable;
    assign busy   = (state != IDLE);
    assign dp     = 1'b1;

`ifdef RESULT_DISPLAY_DECIMAL_EN
    logic [11:0] bcd;
    logic [2:0]  iter;
    logic [3:0]  disp_hi;
    logic [19:0] shifted;

    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int unsigned i = 0; i < 3; i++) begin
            if (r[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    // BCD and remaining binary bits shift as one register, so sh_data doubles as the shift source
    assign shifted = {dabble_adjust(bcd), sh_data} << 1;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef RESULT_DISPLAY_DECIMAL_EN
                    next_state = SHIFT;
`else
                    next_state = UPDATE;
`endif
                end
            end
`ifdef RESULT_DISPLAY_DECIMAL_EN
            SHIFT:  if (iter == 3'd7) next_state = UPDATE;
`endif
            UPDATE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh_data  <= '0;
            sh_sel   <= '0;
            disp_op  <= '0;
            disp_mid <= '0;
            disp_lo  <= '0;
`ifdef RESULT_DISPLAY_DECIMAL_EN
            bcd      <= '0;
            iter     <= '0;
            disp_hi  <= '0;
`endif
        end else begin
            state <= next_state;
            if (accept) begin
                sh_data <= data;
                sh_sel  <= sel;
`ifdef RESULT_DISPLAY_DECIMAL_EN
                bcd     <= '0;
                iter    <= '0;
`endif
            end
`ifdef RESULT_DISPLAY_DECIMAL_EN
            if (state == SHIFT) begin
                bcd     <= shifted[19:8];
                sh_data <= shifted[7:0];
                iter    <= iter + 3'd1;
            end
`endif
            if (state == UPDATE) begin
                disp_op <= sh_sel;
`ifdef RESULT_DISPLAY_DECIMAL_EN
                disp_hi  <= bcd[11:8];
                disp_mid <= bcd[7:4];
                disp_lo  <= bcd[3:0];
`else
                disp_mid <= sh_data[7:4];
                disp_lo  <= sh_data[3:0];
`endif
            end
        end
    end

    always_comb begin
        cur_val   = '0;
        cur_blank = 1'b0;
        case (digit)
            2'd0: cur_val = disp_lo;
            2'd1: cur_val = disp_mid;
`ifdef RESULT_DISPLAY_DECIMAL_EN
            2'd2: cur_val = disp_hi;
`else
            2'd2: cur_blank = 1'b1;
`endif
            default: cur_val = disp_op;
        endcase
    end

    seg_decode u_seg_decode (
        .value (cur_val),
        .blank (cur_blank),
        .seg   (cur_seg)
    );

    // an and seg are registered together so they always switch on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh <= '0;
            digit   <= '0;
            an      <= '1;
            seg     <= BLANK_SEG;
        end else begin
            if (refresh == LAST) begin
                refresh <= '0;
                digit   <= digit + 2'd1;
            end else begin
                refresh <= refresh + CW'(1);
            end
            an  <= ~(4'b0001 << digit);
            seg <= cur_seg;
        end
    end

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display: cycle-level behavioural model plus literal pins.
module tb_result_display;

    localparam int DIV = 4;
`ifdef RESULT_DISPLAY_DECIMAL_EN
    localparam int BUSY_LEN = 9;
`else
    localparam int BUSY_LEN = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0, load = 1'b0, enable = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] sel = '0;
    logic       busy, dp;
    logic [6:0] seg;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .data(data), .sel(sel), .enable(enable),
        .load(load), .busy(busy), .seg(seg), .an(an), .dp(dp)
    );

    // model: per-digit content {blank, value} indexed by anode position
    int         n_run = 0;
    int         busy_left = 0;
    logic [4:0] disp [4];
    logic [4:0] pend [4];
    logic [6:0] got  [4];

    function automatic logic [6:0] glyph(input logic [4:0] x);
        if (x[4]) return 7'b1111111;
        case (x[3:0])
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_disp();
        for (int i = 0; i < 4; i++) disp[i] = 5'h00;
`ifndef RESULT_DISPLAY_DECIMAL_EN
        disp[2] = 5'h10;
`endif
    endtask

    task automatic model_digits(input int d, input int s);
        pend[3] = 5'(s);
`ifdef RESULT_DISPLAY_DECIMAL_EN
        pend[2] = 5'(d / 100);
        pend[1] = 5'((d / 10) % 10);
        pend[0] = 5'(d % 10);
`else
        pend[2] = 5'h10;
        pend[1] = 5'(d / 16);
        pend[0] = 5'(d % 16);
`endif
    endtask

    // one clock: drive inputs, advance the model, compare every output
    task automatic step(input logic r, input logic l, input logic e,
                        input logic [7:0] d, input logic [3:0] s);
        logic [4:0] prev [4];
        int         idx;
        int         exp_an, exp_seg;
        rst = r; load = l; enable = e; data = d; sel = s;
        @(posedge clk);
        #1;
        prev = disp;
        if (r) begin
            n_run = 0;
            busy_left = 0;
            reset_disp();
            exp_an = 'hF;
            exp_seg = 'h7F;
        end else begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) disp = pend;
            end else if (l && e) begin
                model_digits(int'(d), int'(s));
                busy_left = BUSY_LEN;
            end
            n_run++;
            idx = ((n_run - 1) / DIV) % 4;
            exp_an = 'hF & ~(1 << idx);
            exp_seg = int'(glyph(prev[idx]));
            got[idx] = seg;
        end
        check("an", int'(an), exp_an);
        check("seg", int'(seg), exp_seg);
        check("busy", int'(busy), (busy_left > 0) ? 1 : 0);
        check("dp", int'(dp), 1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
    endtask

    task automatic wait_not_busy();
        for (int k = 0; k < 20 && busy; k++) idle(1);
        check("busy_drain", int'(busy), 0);
    endtask

    initial begin
        int blen;
        reset_disp();
        for (int i = 0; i < 4; i++) begin pend[i] = '0; got[i] = '0; end

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        check("rst_an_lit", int'(an), 'hF);
        check("rst_seg_lit", int'(seg), 'h7F);
        check("rst_busy_lit", int'(busy), 0);

        idle(1);
        check("first_an_lit", int'(an), 'hE);
        idle(4);
        check("scan5_an_lit", int'(an), 'hD);
        idle(4);
        check("scan9_an_lit", int'(an), 'hB);
        idle(4);
        check("scan13_an_lit", int'(an), 'h7);
        idle(4);
        check("scan_wrap_an_lit", int'(an), 'hE);

`ifdef RESULT_DISPLAY_DECIMAL_EN
        step(1'b0, 1'b1, 1'b1, 8'hFF, 4'h0);
`else
        step(1'b0, 1'b1, 1'b1, 8'hA7, 4'hB);
`endif
        blen = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            blen++;
            idle(1);
        end
        check("busy_len_lit", blen, BUSY_LEN);
        idle(20);
`ifdef RESULT_DISPLAY_DECIMAL_EN
        check("dig3_lit", int'(got[3]), 'b1000000);
        check("dig2_lit", int'(got[2]), 'b0100100);
        check("dig1_lit", int'(got[1]), 'b0010010);
        check("dig0_lit", int'(got[0]), 'b0010010);
`else
        check("dig3_lit", int'(got[3]), 'b0000011);
        check("dig2_lit", int'(got[2]), 'b1111111);
        check("dig1_lit", int'(got[1]), 'b0001000);
        check("dig0_lit", int'(got[0]), 'b1111000);
`endif

        // disabled load, then a load landing while busy: neither may alter the display
        step(1'b0, 1'b1, 1'b0, 8'h12, 4'h3);
        check("noenable_busy", int'(busy), 0);
        idle(2);
`ifdef RESULT_DISPLAY_DECIMAL_EN
        step(1'b0, 1'b1, 1'b1, 8'hFF, 4'h0);
`else
        step(1'b0, 1'b1, 1'b1, 8'hA7, 4'hB);
`endif
        step(1'b0, 1'b1, 1'b1, 8'h34, 4'h5);
        wait_not_busy();
        idle(20);
`ifdef RESULT_DISPLAY_DECIMAL_EN
        check("keep3_lit", int'(got[3]), 'b1000000);
        check("keep1_lit", int'(got[1]), 'b0010010);
        check("keep0_lit", int'(got[0]), 'b0010010);
`else
        check("keep3_lit", int'(got[3]), 'b0000011);
        check("keep1_lit", int'(got[1]), 'b0001000);
        check("keep0_lit", int'(got[0]), 'b1111000);
`endif

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)),
                 8'($urandom), 4'($urandom));
        end

        // reset aborting a conversion of 200 partway through
        step(1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        wait_not_busy();
        step(1'b0, 1'b1, 1'b1, 8'd200, 4'h9);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        check("abort_busy_lit", int'(busy), 0);
        idle(20);
        check("abort_d1_lit", int'(got[1]), 'b1000000);
        check("abort_d0_lit", int'(got[0]), 'b1000000);
`ifdef RESULT_DISPLAY_DECIMAL_EN
        check("abort_d2_lit", int'(got[2]), 'b1000000);
`else
        check("abort_d2_lit", int'(got[2]), 'b1111111);
`endif
        step(1'b0, 1'b1, 1'b1, 8'd42, 4'h1);
        check("reload_busy_lit", int'(busy), 1);
        wait_not_busy();
        idle(20);
`ifdef RESULT_DISPLAY_DECIMAL_EN
        check("reload_d0_lit", int'(got[0]), 'b0100100);
        check("reload_d1_lit", int'(got[1]), 'b0011001);
`else
        check("reload_d0_lit", int'(got[0]), 'b0001000);
        check("reload_d1_lit", int'(got[1]), 'b0100100);
`endif
        check("reload_d3_lit", int'(got[3]), 'b1111001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
